sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The block SHALL have parameter DATA_W, default 128, data word width in bits.
REQ-002 The block SHALL have parameter DEPTH, default 1024, number of storage entries; power of two, >= 8.
REQ-003 The block SHALL have parameter UPP_TH, default 4, almost-full margin in entries below DEPTH.
REQ-004 The block SHALL have parameter LOW_TH, default 2, almost-empty level in entries.
REQ-005 The block SHALL have port clk, input, 1 bit, the single clock; all logic on its rising edge.
REQ-006 The block SHALL have port rstn, input, 1 bit, reset that is synchronous and active-high; the name is kept for interface compatibility.
REQ-007 The block SHALL have port i_wren, input, 1 bit, write request.
REQ-008 The block SHALL have port i_wrdata, input, DATA_W bits, write data, sampled with i_wren.
REQ-009 The block SHALL have port i_rden, input, 1 bit, read request.
REQ-010 The block SHALL have port o_rddata, output, DATA_W bits, registered read data.
REQ-011 The block SHALL have port o_full, output, 1 bit, high when count == DEPTH.
REQ-012 The block SHALL have port o_empty, output, 1 bit, high when count == 0.
REQ-013 The block SHALL have port o_alm_full, output, 1 bit, high when count >= DEPTH-UPP_TH.
REQ-014 The block SHALL have port o_alm_empty, output, 1 bit, high when count <= LOW_TH.

Function
REQ-015 The block SHALL store data in a DEPTH-entry memory addressed by write and read pointers, each log2(DEPTH) bits wide, wrapping from DEPTH-1 to 0.
REQ-016 The block SHALL keep an occupancy count of log2(DEPTH)+1 bits, range 0..DEPTH.
REQ-017 Write accepted = i_wren && (!o_full || rd_accepted); the word is stored at wr_ptr and wr_ptr increments on the same edge.
REQ-018 Read accepted = i_rden && !o_empty; o_rddata SHALL present mem[rd_ptr] one cycle after the accepting edge, and rd_ptr SHALL increment.
REQ-019 Read latency SHALL be exactly 1 clock; there is no fall-through, and a word written at edge N is readable no earlier than a read request at edge N+1.
REQ-020 o_rddata SHALL hold its last value when no read is accepted, including reads to an empty FIFO.
REQ-021 A write while full with no accepted read SHALL be dropped: memory, pointers and count are unchanged.
REQ-022 A read while empty SHALL be ignored, even when a write occurs on the same edge; only the write takes effect and the count goes from 0 to 1.
REQ-023 A simultaneous accepted read and write (including when full) SHALL leave the count unchanged while both pointers advance.
REQ-024 The count SHALL be updated as +1 for write only, -1 for read only, and 0 for both or neither.
REQ-025 All four flags SHALL be registered and consistent with the post-edge count in the same cycle as the count (zero-cycle flag lag relative to the count).
REQ-026 When both are high, o_full and o_alm_full SHALL be asserted together, and likewise o_empty and o_alm_empty.

Reset
REQ-027 With rstn high at a rising edge, the block SHALL set wr_ptr=0, rd_ptr=0, count=0, o_rddata=0, o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0.
REQ-028 Reset SHALL take priority over simultaneous i_wren/i_rden; requests in a reset cycle are discarded.
REQ-029 Reset mid-operation SHALL discard all stored contents logically; memory need not be cleared, and a following read returns only data written after reset.
REQ-030 The first write SHALL be accepted at the first rising edge with rstn low.

Verification (bench parameters: DATA_W=128, DEPTH=16, UPP_TH=4, LOW_TH=2)
REQ-031 Reset release -> o_empty=1, o_alm_empty=1, o_full=0, o_alm_full=0, o_rddata=0.
REQ-032 Write 0x1..0x10 on 16 consecutive cycles -> o_alm_empty drops after the 3rd write, o_alm_full rises after the 12th, o_full rises after the 16th; a 17th write of 0xFF is dropped.
REQ-033 From full, read 16 consecutive cycles -> o_rddata sequence 0x1..0x10, each 1 cycle after its read edge; o_empty=1 after the last read; a 17th read leaves o_rddata=0x10.
REQ-034 Empty FIFO, i_wren=1 and i_rden=1 with data 0xA5 -> count=1, o_empty=0, o_rddata unchanged; the next read returns 0xA5.
REQ-035 Full FIFO, simultaneous read and write of 0x77 for 20 cycles -> o_full stays 1 and pointers wrap; draining yields 0x77 as the last 16 words.
REQ-036 Write 5 words, assert rstn for 1 cycle with i_wren=1, then write 0xBEEF and read -> o_rddata=0xBEEF, flags return to empty.

Source files
------------

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock FIFO, registered read data and registered flags.
// Ports: clk, rstn (sync, active-high), i_wren/i_wrdata, i_rden/o_rddata, o_full/o_empty/o_alm_full/o_alm_empty.
module sync_fifo #(
  parameter int DATA_W = 128,
  parameter int DEPTH  = 1024,
  parameter int UPP_TH = 4,
  parameter int LOW_TH = 2
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] C_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] C_AF   = CW'(DEPTH - UPP_TH);
  localparam logic [CW-1:0] C_AE   = CW'(LOW_TH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CW-1:0]     cnt;
  logic [CW-1:0]     cnt_nxt;
  logic              rd_acc;
  logic              wr_acc;

  // A read frees a slot on the same edge, so a full FIFO can still
  // accept a write when it is also being read.
  assign rd_acc = i_rden && !o_empty;
  assign wr_acc = i_wren && (!o_full || rd_acc);

  always_comb begin
    cnt_nxt = cnt;
    unique case (1'b1)
      wr_acc && !rd_acc: cnt_nxt = cnt + CW'(1);
      rd_acc && !wr_acc: cnt_nxt = cnt - CW'(1);
      default:           cnt_nxt = cnt;
    endcase
  end

  // Storage is never reset; reset only discards it logically.
  always_ff @(posedge clk) begin
    if (!rstn && wr_acc) begin
      mem[wr_ptr] <= i_wrdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      cnt         <= '0;
      o_rddata    <= '0;
      o_full      <= 1'b0;
      o_empty     <= 1'b1;
      o_alm_full  <= 1'b0;
      o_alm_empty <= 1'b1;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
      if (rd_acc) begin
        rd_ptr   <= rd_ptr + AW'(1);
        o_rddata <= mem[rd_ptr];
      end
      cnt         <= cnt_nxt;
      // Flags come from the next count so they line up with cnt.
      o_full      <= (cnt_nxt == C_FULL);
      o_empty     <= (cnt_nxt == '0);
      o_alm_full  <= (cnt_nxt >= C_AF);
      o_alm_empty <= (cnt_nxt <= C_AE);
    end
  end

endmodule

// File: tb/tb_sync_fifo.sv
// tb_sync_fifo: scoreboard bench for sync_fifo with a queue model.
// Directed scenarios followed by randomized traffic and resets.
module tb_sync_fifo;

  localparam int DW  = 128;
  localparam int DEP = 16;
  localparam int UTH = 4;
  localparam int LTH = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          i_wren = 1'b0;
  logic [DW-1:0] i_wrdata = '0;
  logic          i_rden = 1'b0;
  logic [DW-1:0] o_rddata;
  logic          o_full;
  logic          o_empty;
  logic          o_alm_full;
  logic          o_alm_empty;

  int n_tests = 0;
  int n_fail  = 0;

  sync_fifo #(
    .DATA_W(DW),
    .DEPTH (DEP),
    .UPP_TH(UTH),
    .LOW_TH(LTH)
  ) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i_wren     (i_wren),
    .i_wrdata   (i_wrdata),
    .i_rden     (i_rden),
    .o_rddata   (o_rddata),
    .o_full     (o_full),
    .o_empty    (o_empty),
    .o_alm_full (o_alm_full),
    .o_alm_empty(o_alm_empty)
  );

  always #5 clk = ~clk;

  // Reference: contents as a queue, expected read words as a scoreboard.
  logic [DW-1:0] mq[$];
  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_last = '0;
  bit            rd_fire = 1'b0;
  bit            armed = 1'b0;

  always @(posedge clk) begin
    bit rd_ok;
    bit wr_ok;
    rd_fire = 1'b0;
    if (rstn) begin
      mq.delete();
      sb.delete();
      exp_last = '0;
      armed = 1'b1;
    end else begin
      rd_ok = i_rden && (mq.size() != 0);
      wr_ok = i_wren && ((mq.size() < DEP) || rd_ok);
      if (rd_ok) begin
        sb.push_back(mq.pop_front());
        rd_fire = 1'b1;
      end
      if (wr_ok) mq.push_back(i_wrdata);
    end
  end

  task automatic chk(input string nm, input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Monitor: one cycle after each accepted read the word is due.
  always @(negedge clk) begin
    int c;
    if (armed) begin
      if (rd_fire) begin
        if (sb.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL scoreboard_underflow at %0t", $time);
        end else begin
          exp_last = sb.pop_front();
        end
        rd_fire = 1'b0;
      end
      c = mq.size();
      chk("rddata", o_rddata, exp_last);
      chk("full", DW'(o_full), DW'(c == DEP));
      chk("empty", DW'(o_empty), DW'(c == 0));
      chk("alm_full", DW'(o_alm_full), DW'(c >= DEP - UTH));
      chk("alm_empty", DW'(o_alm_empty), DW'(c <= LTH));
    end
  end

  task automatic cyc(input logic r, input logic w, input logic rd,
                     input logic [DW-1:0] d);
    @(negedge clk);
    rstn     = r;
    i_wren   = w;
    i_rden   = rd;
    i_wrdata = d;
  endtask

  function automatic logic [DW-1:0] rnd();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    cyc(1, 0, 0, '0);
    cyc(1, 1, 1, 'h55);
    cyc(0, 0, 0, '0);
    for (int i = 1; i <= 17; i++)
      cyc(0, 1, 0, (i == 17) ? DW'('hFF) : DW'(i));
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 1, 1, 'hA5);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    for (int i = 0; i < 16; i++) cyc(0, 1, 0, rnd());
    for (int i = 0; i < 20; i++) cyc(0, 1, 1, 'h77);
    for (int i = 0; i < 17; i++) cyc(0, 0, 1, '0);
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, DW'(i + 100));
    cyc(1, 1, 0, 'hDEAD);
    cyc(0, 1, 0, 'hBEEF);
    cyc(0, 0, 1, '0);
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 300) % 3;
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 3) < (bias == 0 ? 3 : (bias == 1 ? 1 : 2))),
          ($urandom_range(0, 3) < (bias == 1 ? 3 : (bias == 0 ? 1 : 2))),
          rnd());
    end
    cyc(0, 0, 0, '0);
    cyc(0, 0, 0, '0);
    @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

endmodule
